// File: rtl/exu_pkg.sv
// Shared types for the execution-unit writeback path: buffered write entry,
// default pending-buffer depth and the writeback source priority order.
package exu_pkg;

  localparam int WB_FIFO_DEPTH_DEF = 4;

  typedef struct packed {
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } wb_entry_t;

  // Declaration order is the arbitration priority, highest first.
  typedef enum logic [1:0] {
    WB_FIFO,
    WB_MD,
    WB_LSU,
    WB_ALU
  } wb_src_e;

  // Maps the arbiter's request slot (0 = mul/div, 1 = LSU, 2 = ALU) to its source tag.
  function automatic wb_src_e req_src(input logic [1:0] idx);
    case (idx)
      2'd0:    return WB_MD;
      2'd1:    return WB_LSU;
      default: return WB_ALU;
    endcase
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Pending-write circular buffer: up to 3 pushes and 1 pop per cycle, head visible same cycle.
// Caller must never push past free space; pop only while count is non-zero.
module wb_fifo
  import exu_pkg::*;
#(
  parameter int DEPTH = WB_FIFO_DEPTH_DEF,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              push_n_i,
  input  wb_entry_t [2:0]         push_dat_i,
  input  logic                    pop_i,
  output wb_entry_t               head_o,
  output logic [CW-1:0]           count_o
);

  wb_entry_t             mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DEPTH-1:0]      wr_en;
  wb_entry_t [DEPTH-1:0] wr_dat;

  // Scatter the in-order pushes onto consecutive slots starting at the write pointer.
  always_comb begin
    wr_en  = '0;
    wr_dat = '0;
    for (int k = 0; k < 3; k++) begin
      if (2'(k) < push_n_i) begin
        wr_en[wr_ptr_q + AW'(k)]  = 1'b1;
        wr_dat[wr_ptr_q + AW'(k)] = push_dat_i[k];
      end
    end
    wr_ptr_d = wr_ptr_q + AW'(push_n_i);
    rd_ptr_d = rd_ptr_q + AW'(pop_i);
    count_d  = count_q + CW'(push_n_i) - CW'(pop_i);
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_mem
    always_ff @(posedge clk) begin
      if (wr_en[i]) mem_q[i] <= wr_dat[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/exu_wb_arb.sv
// Register-file writeback arbiter with mul/div destination scoreboard; zero added latency.
// Losers are buffered; stall_o throttles upstream, overflow drops lowest priority and sets err_o.
module exu_wb_arb
  import exu_pkg::*;
#(
  parameter int FIFO_DEPTH = WB_FIFO_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_we_i,
  input  logic [4:0]  alu_waddr_i,
  input  logic [31:0] alu_wdata_i,
  input  logic        lsu_we_i,
  input  logic [4:0]  lsu_waddr_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic        md_issue_i,
  input  logic [4:0]  md_rd_i,
  input  logic        md_we_i,
  input  logic [31:0] md_wdata_i,
  output logic        reg_we_o,
  output logic [4:0]  reg_waddr_o,
  output logic [31:0] reg_wdata_o,
  output logic [31:0] rd_busy_o,
  output logic        stall_o,
  output logic        md_pend_o,
  output logic        err_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic            md_pend_q, md_pend_d;
  logic [4:0]      md_rd_q, md_rd_d;
  logic            err_q, err_d;

  logic            md_done, md_err_we, md_err_iss, md_load;
  logic [2:0]      req_vld;
  wb_entry_t [2:0] req_dat;

  logic [CW-1:0]   fifo_cnt;
  wb_entry_t       fifo_head;
  logic            fifo_pop;
  logic [1:0]      push_n;
  wb_entry_t [2:0] push_dat;
  logic [CW-1:0]   slots;
  logic            drop;

  logic            win_vld;
  wb_src_e         win_src;
  wb_entry_t       win_dat;

  assign md_done    = md_we_i & md_pend_q;
  assign md_err_we  = md_we_i & ~md_pend_q;
  assign md_err_iss = md_issue_i & md_pend_q & ~md_we_i;
  assign md_load    = md_issue_i & ~md_err_iss;

  // Request slots in priority order; x0 targets are silently discarded.
  assign req_vld[0] = rst_n & md_done & (md_rd_q != 5'd0);
  assign req_vld[1] = rst_n & lsu_we_i & (lsu_waddr_i != 5'd0);
  assign req_vld[2] = rst_n & alu_we_i & (alu_waddr_i != 5'd0);
  assign req_dat[0] = '{waddr: md_rd_q,     wdata: md_wdata_i};
  assign req_dat[1] = '{waddr: lsu_waddr_i, wdata: lsu_wdata_i};
  assign req_dat[2] = '{waddr: alu_waddr_i, wdata: alu_wdata_i};

  always_comb begin
    win_vld = 1'b1;
    win_src = WB_FIFO;
    win_dat = fifo_head;
    if (fifo_cnt == '0) begin
      if (req_vld[0]) begin
        win_src = WB_MD;
        win_dat = req_dat[0];
      end else if (req_vld[1]) begin
        win_src = WB_LSU;
        win_dat = req_dat[1];
      end else if (req_vld[2]) begin
        win_src = WB_ALU;
        win_dat = req_dat[2];
      end else begin
        win_vld = 1'b0;
        win_dat = '0;
      end
    end
  end

  // Losers fill free space in priority order; the head pop frees one slot this cycle.
  always_comb begin
    fifo_pop = (fifo_cnt != '0);
    slots    = CW'(FIFO_DEPTH) - fifo_cnt + CW'(fifo_pop);
    push_n   = '0;
    push_dat = '0;
    drop     = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (req_vld[k] && !(win_vld && win_src == req_src(2'(k)))) begin
        if (CW'(push_n) < slots) begin
          push_dat[push_n] = req_dat[k];
          push_n           = push_n + 2'd1;
        end else begin
          drop = 1'b1;
        end
      end
    end
  end

  always_comb begin
    md_pend_d = md_pend_q;
    md_rd_d   = md_rd_q;
    if (md_done) md_pend_d = 1'b0;
    if (md_load) begin
      md_pend_d = 1'b1;
      md_rd_d   = md_rd_i;
    end
    err_d = err_q | md_err_we | md_err_iss | drop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_pend_q <= 1'b0;
      md_rd_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      md_pend_q <= md_pend_d;
      md_rd_q   <= md_rd_d;
      err_q     <= err_d;
    end
  end

  wb_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_n_i  (push_n),
    .push_dat_i(push_dat),
    .pop_i     (fifo_pop),
    .head_o    (fifo_head),
    .count_o   (fifo_cnt)
  );

  assign reg_we_o    = win_vld;
  assign reg_waddr_o = win_dat.waddr;
  assign reg_wdata_o = win_dat.wdata;
  assign rd_busy_o   = md_pend_q ? (32'd1 << md_rd_q) : 32'd0;
  assign md_pend_o   = md_pend_q;
  assign err_o       = err_q;
  assign stall_o     = (fifo_cnt >= CW'(FIFO_DEPTH - 2)) | md_err_iss;

endmodule

// File: tb/tb_exu_wb_arb.sv
// Directed bench for exu_wb_arb: a vector table for the steady-state flows, then
// hand-written sequences for protocol errors, same-cycle issue/complete and mid-run reset.
module tb_exu_wb_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_we_i, lsu_we_i, md_issue_i, md_we_i;
  logic [4:0]  alu_waddr_i, lsu_waddr_i, md_rd_i;
  logic [31:0] alu_wdata_i, lsu_wdata_i, md_wdata_i;
  logic        reg_we_o, stall_o, md_pend_o, err_o;
  logic [4:0]  reg_waddr_o;
  logic [31:0] reg_wdata_o, rd_busy_o;

  int checks = 0;
  int errors = 0;

  exu_wb_arb #(.FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_we_i   (alu_we_i),
    .alu_waddr_i(alu_waddr_i),
    .alu_wdata_i(alu_wdata_i),
    .lsu_we_i   (lsu_we_i),
    .lsu_waddr_i(lsu_waddr_i),
    .lsu_wdata_i(lsu_wdata_i),
    .md_issue_i (md_issue_i),
    .md_rd_i    (md_rd_i),
    .md_we_i    (md_we_i),
    .md_wdata_i (md_wdata_i),
    .reg_we_o   (reg_we_o),
    .reg_waddr_o(reg_waddr_o),
    .reg_wdata_o(reg_wdata_o),
    .rd_busy_o  (rd_busy_o),
    .stall_o    (stall_o),
    .md_pend_o  (md_pend_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        alu_we;
    logic [4:0]  alu_a;
    logic [31:0] alu_d;
    logic        lsu_we;
    logic [4:0]  lsu_a;
    logic [31:0] lsu_d;
    logic        md_iss;
    logic [4:0]  md_rd;
    logic        md_we;
    logic [31:0] md_d;
    logic        e_we;
    logic [4:0]  e_a;
    logic [31:0] e_d;
    logic [31:0] e_busy;
    logic        e_stall;
    logic        e_pend;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
      input logic aw, input logic [4:0] aa, input logic [31:0] ad,
      input logic lw, input logic [4:0] la, input logic [31:0] ld,
      input logic mi, input logic [4:0] mr, input logic mw, input logic [31:0] md,
      input logic ew, input logic [4:0] ea, input logic [31:0] ed,
      input logic [31:0] eb, input logic es, input logic ep, input logic ee);
    vec_t v;
    v.alu_we = aw; v.alu_a = aa; v.alu_d = ad;
    v.lsu_we = lw; v.lsu_a = la; v.lsu_d = ld;
    v.md_iss = mi; v.md_rd = mr; v.md_we = mw; v.md_d = md;
    v.e_we = ew; v.e_a = ea; v.e_d = ed;
    v.e_busy = eb; v.e_stall = es; v.e_pend = ep; v.e_err = ee;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    alu_we_i = 0; alu_waddr_i = 0; alu_wdata_i = 0;
    lsu_we_i = 0; lsu_waddr_i = 0; lsu_wdata_i = 0;
    md_issue_i = 0; md_rd_i = 0; md_we_i = 0; md_wdata_i = 0;
  endtask

  task automatic drive(input vec_t v);
    alu_we_i = v.alu_we; alu_waddr_i = v.alu_a; alu_wdata_i = v.alu_d;
    lsu_we_i = v.lsu_we; lsu_waddr_i = v.lsu_a; lsu_wdata_i = v.lsu_d;
    md_issue_i = v.md_iss; md_rd_i = v.md_rd; md_we_i = v.md_we; md_wdata_i = v.md_d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    // ALU-only write, x0 drop, mul/div flow
    tbl.push_back(mk(0,0,0,        0,0,0,        0,0, 0,0,            0,0,0,            0,0,0,0));
    tbl.push_back(mk(1,5,32'h11,   0,0,0,        0,0, 0,0,            1,5,32'h11,       0,0,0,0));
    tbl.push_back(mk(0,0,0,        0,0,0,        0,0, 0,0,            0,0,0,            0,0,0,0));
    tbl.push_back(mk(1,0,32'h99,   0,0,0,        0,0, 0,0,            0,0,0,            0,0,0,0));
    tbl.push_back(mk(0,0,0,        0,0,0,        1,7, 0,0,            0,0,0,            0,0,0,0));
    tbl.push_back(mk(0,0,0,        0,0,0,        0,0, 0,0,            0,0,0,            32'h80,0,1,0));
    tbl.push_back(mk(0,0,0,        0,0,0,        0,0, 0,0,            0,0,0,            32'h80,0,1,0));
    tbl.push_back(mk(0,0,0,        0,0,0,        0,0, 1,32'hDEADBEEF, 1,7,32'hDEADBEEF, 32'h80,0,1,0));
    tbl.push_back(mk(0,0,0,        0,0,0,        0,0, 0,0,            0,0,0,            0,0,0,0));
    // triple collision
    tbl.push_back(mk(0,0,0,        0,0,0,        1,3, 0,0,            0,0,0,            0,0,0,0));
    tbl.push_back(mk(1,5,32'h55,   1,4,32'h44,   0,0, 1,32'h33,       1,3,32'h33,       32'h8,0,1,0));
    tbl.push_back(mk(0,0,0,        0,0,0,        0,0, 0,0,            1,4,32'h44,       0,1,0,0));
    tbl.push_back(mk(0,0,0,        0,0,0,        0,0, 0,0,            1,5,32'h55,       0,0,0,0));
    tbl.push_back(mk(0,0,0,        0,0,0,        0,0, 0,0,            0,0,0,            0,0,0,0));
    // fill to 3 entries, then overflow with a triple collision
    tbl.push_back(mk(0,0,0,        0,0,0,        1,7, 0,0,            0,0,0,            0,0,0,0));
    tbl.push_back(mk(1,2,32'hA2,   1,1,32'hA1,   0,0, 0,0,            1,1,32'hA1,       32'h80,0,1,0));
    tbl.push_back(mk(1,4,32'hA4,   1,3,32'hA3,   0,0, 0,0,            1,2,32'hA2,       32'h80,0,1,0));
    tbl.push_back(mk(1,6,32'hA6,   1,5,32'hA5,   0,0, 0,0,            1,3,32'hA3,       32'h80,1,1,0));
    tbl.push_back(mk(1,9,32'hA9,   1,8,32'hA8,   0,0, 1,32'hA7,       1,4,32'hA4,       32'h80,1,1,0));
    tbl.push_back(mk(0,0,0,        0,0,0,        0,0, 0,0,            1,5,32'hA5,       0,1,0,1));
    tbl.push_back(mk(0,0,0,        0,0,0,        0,0, 0,0,            1,6,32'hA6,       0,1,0,1));
    tbl.push_back(mk(0,0,0,        0,0,0,        0,0, 0,0,            1,7,32'hA7,       0,1,0,1));
    tbl.push_back(mk(0,0,0,        0,0,0,        0,0, 0,0,            1,8,32'hA8,       0,0,0,1));
    tbl.push_back(mk(0,0,0,        0,0,0,        0,0, 0,0,            0,0,0,            0,0,0,1));

    // reset state, observed while rst_n is still low
    @(negedge clk);
    #2;
    chk("rst reg_we",  32'(reg_we_o),  32'd0);
    chk("rst busy",    rd_busy_o,      32'd0);
    chk("rst pend",    32'(md_pend_o), 32'd0);
    chk("rst stall",   32'(stall_o),   32'd0);
    chk("rst err",     32'(err_o),     32'd0);
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #2;
      chk($sformatf("v%0d reg_we", i),    32'(reg_we_o),    32'(tbl[i].e_we));
      chk($sformatf("v%0d reg_waddr", i), 32'(reg_waddr_o), 32'(tbl[i].e_a));
      chk($sformatf("v%0d reg_wdata", i), reg_wdata_o,      tbl[i].e_d);
      chk($sformatf("v%0d rd_busy", i),   rd_busy_o,        tbl[i].e_busy);
      chk($sformatf("v%0d stall", i),     32'(stall_o),     32'(tbl[i].e_stall));
      chk($sformatf("v%0d md_pend", i),   32'(md_pend_o),   32'(tbl[i].e_pend));
      chk($sformatf("v%0d err", i),       32'(err_o),       32'(tbl[i].e_err));
    end

    // md result with nothing pending: discarded, err set
    do_reset();
    #2;
    chk("rst2 err", 32'(err_o), 32'd0);
    @(negedge clk);
    md_we_i = 1; md_wdata_i = 32'h55;
    #2;
    chk("orphan md reg_we", 32'(reg_we_o), 32'd0);
    @(negedge clk);
    idle();
    #2;
    chk("orphan md err",  32'(err_o),     32'd1);
    chk("orphan md pend", 32'(md_pend_o), 32'd0);

    // same-cycle complete+issue, then a second issue while pending
    do_reset();
    @(negedge clk);
    md_issue_i = 1; md_rd_i = 9;
    @(negedge clk);
    md_issue_i = 1; md_rd_i = 10; md_we_i = 1; md_wdata_i = 32'hB0;
    #2;
    chk("swap reg_we",    32'(reg_we_o),    32'd1);
    chk("swap reg_waddr", 32'(reg_waddr_o), 32'd9);
    chk("swap reg_wdata", reg_wdata_o,      32'hB0);
    chk("swap stall",     32'(stall_o),     32'd0);
    chk("swap busy",      rd_busy_o,        32'h200);
    @(negedge clk);
    idle();
    md_issue_i = 1; md_rd_i = 11;
    #2;
    chk("dbl issue stall", 32'(stall_o), 32'd1);
    chk("dbl issue busy",  rd_busy_o,    32'h400);
    chk("dbl issue err0",  32'(err_o),   32'd0);
    @(negedge clk);
    idle();
    #2;
    chk("dbl issue err",  32'(err_o),     32'd1);
    chk("dbl issue keep", rd_busy_o,      32'h400);
    chk("dbl issue pend", 32'(md_pend_o), 32'd1);

    // reset with 2 entries buffered and an md result outstanding
    do_reset();
    @(negedge clk);
    md_issue_i = 1; md_rd_i = 12;
    @(negedge clk);
    idle();
    lsu_we_i = 1; lsu_waddr_i = 1; lsu_wdata_i = 32'hC1;
    alu_we_i = 1; alu_waddr_i = 2; alu_wdata_i = 32'hC2;
    @(negedge clk);
    lsu_waddr_i = 3; lsu_wdata_i = 32'hC3;
    alu_waddr_i = 4; alu_wdata_i = 32'hC4;
    #2;
    chk("pre-rst head", 32'(reg_waddr_o), 32'd2);
    @(negedge clk);
    idle();
    alu_we_i = 1; alu_waddr_i = 6; alu_wdata_i = 32'h66;
    rst_n = 0;
    #2;
    chk("in-rst reg_we", 32'(reg_we_o),  32'd0);
    chk("in-rst stall",  32'(stall_o),   32'd0);
    chk("in-rst busy",   rd_busy_o,      32'd0);
    @(negedge clk);
    idle();
    rst_n = 1;
    #2;
    chk("post-rst reg_we", 32'(reg_we_o),  32'd0);
    chk("post-rst err",    32'(err_o),     32'd0);
    chk("post-rst busy",   rd_busy_o,      32'd0);
    chk("post-rst pend",   32'(md_pend_o), 32'd0);
    chk("post-rst stall",  32'(stall_o),   32'd0);
    @(negedge clk);
    alu_we_i = 1; alu_waddr_i = 6; alu_wdata_i = 32'h66;
    #2;
    chk("new req we",    32'(reg_we_o),    32'd1);
    chk("new req waddr", 32'(reg_waddr_o), 32'd6);
    chk("new req wdata", reg_wdata_o,      32'h66);
    @(negedge clk);
    idle();
    #2;
    chk("no stale entry", 32'(reg_we_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
